// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between the EX stage and the multi-cycle divider.
//
// Signals
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend, WIDTH bits
//   opdata2_i     divisor, WIDTH bits
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancel for a divide sitting in a flushed slot
//   result_o      {remainder, quotient}, 2*WIDTH bits, registered
//   ready_o       result valid, registered
//
// Modports
//   master  EX-stage side (drives request, observes result)
//   slave   divider side
//
// The WIDTH parameter must match the WIDTH of the div_unit it is bound to.
// -----------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle integer divider for DIV / DIVU. One radix-2 restoring step per
// clock; WIDTH steps per divide. The result is {remainder, quotient}, which the
// pipeline writes as HI = remainder, LO = quotient.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset (clears state, result and ready)
//   bus   div_unit_if.slave: signed_div_i, opdata1_i, opdata2_i, start_i,
//         annul_i in; result_o, ready_o out (both registered)
//
// Latency
//   Request sampled on edge E0, iterations on E1..E(WIDTH), result and ready
//   visible after E(WIDTH). The result is held while start_i stays high and
//   cleared one edge after start_i drops.
//
// Configuration macro
//   DIV_ZERO_FAST_EN  defined: a zero divisor goes through the one-cycle
//                     BYZERO state and finishes with result 0 after E1.
//                     undefined: a zero divisor runs the normal iteration,
//                     giving quotient all-ones and remainder = dividend
//                     (sign-fixed in signed mode).
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BYZERO = 2'b01;
  localparam logic [1:0] ON     = 2'b10;
  localparam logic [1:0] END    = 2'b11;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [1:0]           state_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     rem_r;      // partial remainder
  logic [WIDTH-1:0]     dvd_r;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs_r;      // divisor magnitude
  logic                 neg_quo_r;  // operand signs differed (signed mode)
  logic                 neg_rem_r;  // dividend was negative (signed mode)
  logic [2*WIDTH-1:0]   result_r;
  logic                 ready_r;

  logic                 op1_neg_s;
  logic                 op2_neg_s;
  logic [WIDTH-1:0]     op1_mag_s;
  logic [WIDTH-1:0]     op2_mag_s;

  logic [WIDTH:0]       shifted_s;
  logic [WIDTH:0]       diff_s;
  logic                 ge_s;
  logic [WIDTH-1:0]     rem_next_s;
  logic [WIDTH-1:0]     quo_next_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;

`ifdef DIV_ZERO_FAST_EN
  logic                 div_zero_s;

  // Zero-divisor detect for the fast BYZERO path.
  always_comb begin
    div_zero_s = (bus.opdata2_i == {WIDTH{1'b0}});
  end
`endif

  // Operand signs and magnitudes presented at request time.
  always_comb begin
    op1_neg_s = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg_s = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    op1_mag_s = neg_if(bus.opdata1_i, op1_neg_s);
    op2_mag_s = neg_if(bus.opdata2_i, op2_neg_s);
  end

  // One restoring step plus the sign-fixed result used on the final step.
  always_comb begin
    shifted_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    // The partial remainder always stays below the divisor, so bit WIDTH of
    // the difference is set exactly when the trial subtract went negative.
    ge_s      = ~diff_s[WIDTH];
    if (ge_s) begin
      rem_next_s = diff_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {dvd_r[WIDTH-2:0], ge_s};
    // -2^(WIDTH-1) / -1 wraps to 0x8000... here with no exception.
    quo_fix_s  = neg_if(quo_next_s, neg_quo_r);
    rem_fix_s  = neg_if(rem_next_s, neg_rem_r);
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= FREE;
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      dvd_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= {(2*WIDTH){1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        FREE: begin
          result_r <= {(2*WIDTH){1'b0}};
          ready_r  <= 1'b0;
          if (bus.annul_i) begin
            state_r <= FREE;
          end else if (bus.start_i) begin
            rem_r     <= {WIDTH{1'b0}};
            dvd_r     <= op1_mag_s;
            dvs_r     <= op2_mag_s;
            neg_quo_r <= op1_neg_s ^ op2_neg_s;
            neg_rem_r <= op1_neg_s;
            cnt_r     <= {CW{1'b0}};
`ifdef DIV_ZERO_FAST_EN
            if (div_zero_s) begin
              state_r <= BYZERO;
            end else begin
              state_r <= ON;
            end
`else
            state_r <= ON;
`endif
          end else begin
            state_r <= FREE;
          end
        end

        BYZERO: begin
          if (bus.annul_i || !bus.start_i) begin
            state_r  <= FREE;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
          end else begin
            state_r  <= END;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b1;
          end
        end

        ON: begin
          if (bus.annul_i || !bus.start_i) begin
            state_r  <= FREE;
            cnt_r    <= {CW{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
          end else if (cnt_r == LAST_ITER) begin
            state_r  <= END;
            cnt_r    <= {CW{1'b0}};
            rem_r    <= rem_next_s;
            dvd_r    <= quo_next_s;
            result_r <= {rem_fix_s, quo_fix_s};
            ready_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= rem_next_s;
            dvd_r <= quo_next_s;
          end
        end

        END: begin
          // annul_i is deliberately ignored here: only start_i releases END.
          if (bus.start_i) begin
            state_r <= END;
          end else begin
            state_r  <= FREE;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
          end
        end

        default: begin
          state_r  <= FREE;
          cnt_r    <= {CW{1'b0}};
          result_r <= {(2*WIDTH){1'b0}};
          ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int LAT = 33;

  logic clk;
  logic rst;

  int checks;
  int fails;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one divide from FREE: holds start until ready (bounded), captures the
  // result, drops start and captures the outputs one edge later.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res,
                        output logic rdy_after, output logic [63:0] res_after);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    lat = 0;
    while (bus.ready_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    res = bus.result_o;
    bus.start_i = 1'b0;
    tick();
    rdy_after = bus.ready_o;
    res_after = bus.result_o;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd0;
    bus.opdata2_i = 32'd0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #3;
    checks++;
    if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    checks++;
    if (bus.result_o !== 64'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    bus.start_i = 1'b1;
    bus.opdata1_i = 32'd7;
    bus.opdata2_i = 32'd2;
    tick();
    checks++;
    if (dut.state_r !== 2'b00) begin fails++; $display("FAIL reset_hold_state: got %b expected 00", dut.state_r); end
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_divu;
    logic [31:0] va [0:4];
    logic [31:0] vb [0:4];
    logic [63:0] ve [0:4];
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    va[0] = 32'd7;          vb[0] = 32'd2; ve[0] = {32'h00000001, 32'h00000003};
    va[1] = 32'd100;        vb[1] = 32'd7; ve[1] = {32'h00000002, 32'h0000000E};
    va[2] = 32'hFFFFFFFF;   vb[2] = 32'd1; ve[2] = {32'h00000000, 32'hFFFFFFFF};
    va[3] = 32'd3;          vb[3] = 32'd5; ve[3] = {32'h00000003, 32'h00000000};
    va[4] = 32'hFFFFFFF9;   vb[4] = 32'd2; ve[4] = {32'h00000001, 32'h7FFFFFFC};
    for (int i = 0; i < 5; i++) begin
      do_div(1'b0, va[i], vb[i], lat, res, rdy_after, res_after);
      checks++;
      if (lat != LAT) begin fails++; $display("FAIL divu_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
      checks++;
      if (res !== ve[i]) begin fails++; $display("FAIL divu_res[%0d]: got %h expected %h", i, res, ve[i]); end
      checks++;
      if (rdy_after !== 1'b0) begin fails++; $display("FAIL divu_clr_ready[%0d]: got %b expected 0", i, rdy_after); end
      checks++;
      if (res_after !== 64'd0) begin fails++; $display("FAIL divu_clr_result[%0d]: got %h expected 0", i, res_after); end
    end
  endtask

  task automatic test_div_signed;
    logic [31:0] va [0:4];
    logic [31:0] vb [0:4];
    logic [63:0] ve [0:4];
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        ve[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; ve[1] = {32'h00000000, 32'h80000000};
    va[2] = 32'd7;        vb[2] = 32'hFFFFFFFE; ve[2] = {32'h00000001, 32'hFFFFFFFD};
    va[3] = 32'hFFFFFFF9; vb[3] = 32'hFFFFFFFE; ve[3] = {32'hFFFFFFFF, 32'h00000003};
    va[4] = 32'h80000000; vb[4] = 32'd2;        ve[4] = {32'h00000000, 32'hC0000000};
    for (int i = 0; i < 5; i++) begin
      do_div(1'b1, va[i], vb[i], lat, res, rdy_after, res_after);
      checks++;
      if (lat != LAT) begin fails++; $display("FAIL div_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
      checks++;
      if (res !== ve[i]) begin fails++; $display("FAIL div_res[%0d]: got %h expected %h", i, res, ve[i]); end
      checks++;
      if (rdy_after !== 1'b0) begin fails++; $display("FAIL div_clr_ready[%0d]: got %b expected 0", i, rdy_after); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    int exp_lat;
    logic [63:0] exp_u;
    logic [63:0] exp_s;
`ifdef DIV_ZERO_FAST_EN
    exp_lat = 2;
    exp_u = 64'd0;
    exp_s = 64'd0;
`else
    exp_lat = LAT;
    exp_u = {32'h00000005, 32'hFFFFFFFF};
    exp_s = {32'hFFFFFFFB, 32'h00000001};
`endif
    do_div(1'b0, 32'd5, 32'd0, lat, res, rdy_after, res_after);
    checks++;
    if (lat != exp_lat) begin fails++; $display("FAIL divz_u_lat: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (res !== exp_u) begin fails++; $display("FAIL divz_u_res: got %h expected %h", res, exp_u); end
    checks++;
    if (rdy_after !== 1'b0) begin fails++; $display("FAIL divz_u_clr: got %b expected 0", rdy_after); end
    do_div(1'b1, 32'hFFFFFFFB, 32'd0, lat, res, rdy_after, res_after);
    checks++;
    if (lat != exp_lat) begin fails++; $display("FAIL divz_s_lat: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (res !== exp_s) begin fails++; $display("FAIL divz_s_res: got %h expected %h", res, exp_s); end
  endtask

  task automatic test_end_hold;
    int n;
    n = 0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd7;
    bus.opdata2_i = 32'd2;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b0;
    while (bus.ready_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    bus.annul_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== {32'h00000001, 32'h00000003}) begin
        fails++;
        $display("FAIL end_hold[%0d]: got ready=%b result=%h expected ready=1 result=%h",
                 i, bus.ready_o, bus.result_o, {32'h00000001, 32'h00000003});
      end
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();
    checks++;
    if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL end_release: got %b expected 0", bus.ready_o); end
  endtask

  task automatic test_annul;
    int seen;
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    // annul wins over start in FREE
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd3;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    tick();
    checks++;
    if (dut.state_r !== 2'b00) begin fails++; $display("FAIL annul_free_state: got %b expected 00", dut.state_r); end
    // annul pulsed at E10 of a running divide
    bus.annul_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    checks++;
    if (dut.state_r !== 2'b00) begin fails++; $display("FAIL annul_on_state: got %b expected 00", dut.state_r); end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen); end
    do_div(1'b0, 32'd100, 32'd3, lat, res, rdy_after, res_after);
    checks++;
    if (res !== {32'h00000001, 32'h00000021}) begin
      fails++; $display("FAIL annul_next_res: got %h expected %h", res, {32'h00000001, 32'h00000021});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd3;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dut.state_r !== 2'b00 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      fails++; $display("FAIL reset_mid_on: got state=%b ready=%b result=%h expected 00/0/0",
                        dut.state_r, bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();
    // reset while a result is being held in END
    bus.opdata1_i = 32'd9;
    bus.start_i = 1'b1;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      fails++; $display("FAIL reset_in_end: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();
    do_div(1'b0, 32'd9, 32'd3, lat, res, rdy_after, res_after);
    checks++;
    if (lat != LAT || res !== {32'h00000000, 32'h00000003}) begin
      fails++; $display("FAIL reset_after_div: got lat=%0d res=%h expected lat=%0d res=%h",
                        lat, res, LAT, {32'h00000000, 32'h00000003});
    end
  endtask

  task automatic test_operand_change;
    int n;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd7;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b1;
    tick();
    n = 1;
    while (bus.ready_o !== 1'b1 && n < 40) begin
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      bus.signed_div_i = ~bus.signed_div_i;
      tick();
      n++;
    end
    checks++;
    if (n != LAT) begin fails++; $display("FAIL opchg_lat: got %0d expected %0d", n, LAT); end
    checks++;
    if (bus.result_o !== {32'h00000006, 32'h0000008E}) begin
      fails++; $display("FAIL opchg_res: got %h expected %h", bus.result_o, {32'h00000006, 32'h0000008E});
    end
    bus.start_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] res;
    logic [63:0] res_after;
    logic rdy_after;
    do_div(1'b0, 32'd7, 32'd2, lat, res, rdy_after, res_after);
    checks++;
    if (res !== {32'h00000001, 32'h00000003}) begin
      fails++; $display("FAIL b2b_first: got %h expected %h", res, {32'h00000001, 32'h00000003});
    end
    // new request presented immediately after the single FREE cycle
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, res, rdy_after, res_after);
    checks++;
    if (lat != LAT || res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      fails++; $display("FAIL b2b_second: got lat=%0d res=%h expected lat=%0d res=%h",
                        lat, res, LAT, {32'hFFFFFFFF, 32'hFFFFFFFD});
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_end_hold();
    test_annul();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the toy MIPS core, sitting beside the EX stage and feeding the HI/LO write path (MEM/WB → hilo_reg). It executes DIV/DIVU with one radix-2 restoring step per clock. It returns `{remainder, quotient}` as a 64-bit result that the pipeline writes as HI = remainder, LO = quotient. EX stalls the pipeline through `ctrl` while `start_i` is high and `ready_o` is low.

## Interface
- `WIDTH`, default 32: operand width. Result width is 2·WIDTH. Iteration count equals WIDTH.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `signed_div_i`  in  1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  WIDTH: dividend.
- `opdata2_i`  in  WIDTH: divisor.
- `start_i`  in  1: request. Held high by EX until `ready_o` is seen.
- `annul_i`  in  1: cancel. Driven when the divide is in a flushed slot.
- `result_o`  out  2·WIDTH: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`. Registered.
- `ready_o`  out  1: result valid. Registered.

## Operation
- States: FREE, BYZERO, ON, END. `rst` low forces FREE, `result_o` = 0, `ready_o` = 0, and iteration counter = 0.
- **FREE**
  - `start_i` = 1 and `annul_i` = 0 with divisor ≠ 0: latch operands, go to ON.
  - For signed mode, operands are latched as magnitudes (two's-complement negation of negative values). Operand signs are latched as well.
  - Divisor = 0: go to BYZERO (behaviour set by the configuration macro).
  - Otherwise stay in FREE.
- **ON**, one iteration per clock:
  - Partial remainder (WIDTH+1 bits) shifts left by one and takes in the next dividend MSB.
  - Trial subtract of the divisor. If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - The counter increments. After WIDTH iterations, go to END.
- **Sign fix on entering END**
  - Quotient is negated if the signs differed (signed mode only).
  - Remainder is negated if the dividend was negative (signed mode only).
  - `-2^(WIDTH-1) / -1` yields quotient `0x80000000` and remainder 0. The wrap is silent, with no exception.
- **END**
  - `result_o` holds the final value and `ready_o` = 1.
  - Stays in END while `start_i` = 1.
  - When `start_i` = 0: go to FREE, clear `ready_o`, set `result_o` to 0.
- **Abort**: in ON or BYZERO, `annul_i` = 1 or `start_i` = 0 returns to FREE on the next edge. `ready_o` stays 0 and `result_o` = 0.
- `annul_i` has priority over `start_i` in every state except END.
- Inputs are ignored outside FREE. Changing the operands while busy has no effect.

## Timing
- Edge E0 samples `start_i` in FREE.
- Iterations run on edges E1..E32.
- After E32 the state is END and `ready_o` = 1. The result is visible in the cycle following E32, i.e. 33 edges after request acceptance, counting E0.
- Back-to-back divides:
  - A minimum of one FREE cycle separates them, because `start_i` must drop before a new request.
  - A new request can therefore be accepted 2 edges after `ready_o` rises.
- `rst` asserted at any point, including mid-ON: outputs clear immediately (asynchronously), with no partial result.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - BYZERO lasts one cycle and then enters END with `result_o` = 0.
  - `ready_o` rises after E1, which gives a 2-edge latency.
- Undefined:
  - BYZERO is not used; a zero divisor proceeds through ON for the full 32 iterations.
  - Unsigned result: quotient `0xFFFFFFFF`, remainder = dividend.
  - Signed mode applies the sign fix to that result.
  - Timing is identical to a normal divide.

## Test plan
- **DIVU 7/2**: `start_i` held from E0 → `ready_o` high after E32, `result_o` = `{0x00000001, 0x00000003}`. `ready_o` and `result_o` clear one edge after `start_i` drops.
- **DIV -7/2** (`0xFFFFFFF9`, 2) → `{0xFFFFFFFF, 0xFFFFFFFD}`. **DIV 0x80000000/0xFFFFFFFF** → `{0x00000000, 0x80000000}`.
- **DIVU 5/0**:
  - With `DIV_ZERO_FAST_EN`: `result_o` = 0, `ready_o` high after E1.
  - Without it: `{0x00000005, 0xFFFFFFFF}` after E32.
- **Annul**: DIVU 100/3 with `annul_i` pulsed at E10 → state FREE after E10, `ready_o` never rises. A following DIVU 100/3 → `{0x00000001, 0x00000021}`.
- **Reset**: `rst` low mid-ON (at E15) → `result_o` = 0 and `ready_o` = 0 without waiting for a clock edge. After release, DIVU 9/3 → `{0x00000000, 0x00000003}`.
- **Operand change**: alter `opdata1_i` / `opdata2_i` during ON → result still reflects the operands latched at E0.
